// File: rtl/arp_test.sv
`default_nettype none
// ============================================================================
// Module : arp_test
// Sends a broadcast ARP request on an MII transmit port at a fixed interval.
// Optional Ethernet FCS when the ARP_TEST_FCS_EN macro is defined.
// Rev    : 1.0
// ============================================================================
module arp_test #(
  parameter logic [47:0] LOCAL_MAC      = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP       = 32'hC0_A8_00_02,
  parameter logic [31:0] TARGET_IP      = 32'hC0_A8_00_03,
  parameter int unsigned PHY_RST_CYCLES = 1000,
  parameter int unsigned INTERVAL       = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ETH_TX_CLK,
  output logic       ETH_TX_EN,
  output logic [3:0] ETH_TX_DATA,
  output logic       ETH_RST_N
);

  typedef enum logic [2:0] {
    WAIT_PHY = 3'd0,
    IDLE     = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    FCS      = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [7:0]  C_LAST_PRE  = 8'd15;
  localparam logic [7:0]  C_LAST_DATA = 8'd135;
  localparam logic [31:0] C_LAST_GAP  = 32'd23;
  localparam logic [479:0] C_FRAME = {
    48'hFFFF_FFFF_FFFF, LOCAL_MAC, 16'h0806,
    16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
    LOCAL_MAC, LOCAL_IP, 48'h0, TARGET_IP, 144'h0
  };

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  nib_q, nib_d;
  logic        en_q, en_d;
  logic [3:0]  data_q, data_d;
  logic        rstn_q, rstn_d;
  logic [2:0]  sync_q;

  logic        w_fall;
  logic [7:0]  w_dpos;
  logic [9:0]  w_shift;
  logic [7:0]  w_dbyte;
  logic [3:0]  w_dnib;

`ifdef ARP_TEST_FCS_EN
  localparam logic [7:0] C_LAST_FCS = 8'd143;
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32 advanced by one nibble, LSB first as it goes on the wire.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  // sync_q[1] is the synchronized clock, sync_q[2] its previous value.
  assign w_fall  = sync_q[2] & ~sync_q[1];

  // Data byte/nibble that follows frame nibble nib_q.
  assign w_dpos  = nib_q - 8'd15;
  assign w_shift = 10'd472 - {w_dpos[7:1], 3'b000};
  assign w_dbyte = 8'(C_FRAME >> w_shift);
  assign w_dnib  = w_dpos[0] ? w_dbyte[7:4] : w_dbyte[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= WAIT_PHY;
      cnt_q   <= '0;
      nib_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= 4'h0;
      rstn_q  <= 1'b0;
`ifdef ARP_TEST_FCS_EN
      crc_q   <= 32'hFFFF_FFFF;
`endif
    end else begin
      sync_q  <= {sync_q[1:0], ETH_TX_CLK};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      en_q    <= en_d;
      data_q  <= data_d;
      rstn_q  <= rstn_d;
`ifdef ARP_TEST_FCS_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    en_d    = en_q;
    data_d  = data_q;
    rstn_d  = rstn_q;
`ifdef ARP_TEST_FCS_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      WAIT_PHY: begin
        rstn_d = 1'b0;
        en_d   = 1'b0;
        data_d = 4'h0;
        if (cnt_q == PHY_RST_CYCLES - 1) begin
          state_d = IDLE;
          rstn_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      IDLE: begin
        if (cnt_q != INTERVAL) begin
          cnt_d = cnt_q + 32'd1;
        end else if (w_fall) begin
          state_d = PREAMBLE;
          nib_d   = '0;
          en_d    = 1'b1;
          data_d  = 4'h5;
`ifdef ARP_TEST_FCS_EN
          crc_d   = 32'hFFFF_FFFF;
`endif
        end
      end
      PREAMBLE: begin
        if (w_fall) begin
          nib_d = nib_q + 8'd1;
          if (nib_q == C_LAST_PRE) begin
            state_d = DATA;
            data_d  = w_dnib;
`ifdef ARP_TEST_FCS_EN
            crc_d   = crc_nib(crc_q, w_dnib);
`endif
          end else begin
            data_d = (nib_q == C_LAST_PRE - 8'd1) ? 4'hD : 4'h5;
          end
        end
      end
      DATA: begin
        if (w_fall) begin
          nib_d = nib_q + 8'd1;
          if (nib_q == C_LAST_DATA) begin
`ifdef ARP_TEST_FCS_EN
            state_d = FCS;
            data_d  = ~crc_q[3:0];
            crc_d   = crc_q >> 4;
`else
            state_d = GAP;
            en_d    = 1'b0;
            data_d  = 4'h0;
            cnt_d   = '0;
`endif
          end else begin
            data_d = w_dnib;
`ifdef ARP_TEST_FCS_EN
            crc_d  = crc_nib(crc_q, w_dnib);
`endif
          end
        end
      end
`ifdef ARP_TEST_FCS_EN
      FCS: begin
        if (w_fall) begin
          nib_d = nib_q + 8'd1;
          if (nib_q == C_LAST_FCS) begin
            state_d = GAP;
            en_d    = 1'b0;
            data_d  = 4'h0;
            cnt_d   = '0;
          end else begin
            data_d = ~crc_q[3:0];
            crc_d  = crc_q >> 4;
          end
        end
      end
`endif
      GAP: begin
        if (w_fall) begin
          if (cnt_q == C_LAST_GAP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_PHY;
        cnt_d   = '0;
        en_d    = 1'b0;
        data_d  = 4'h0;
        rstn_d  = 1'b0;
      end
    endcase
  end

  assign ETH_TX_EN   = en_q;
  assign ETH_TX_DATA = data_q;
  assign ETH_RST_N   = rstn_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_test.sv
`default_nettype none
// ============================================================================
// Module : tb_arp_test
// Directed bench for arp_test with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_arp_test;
  localparam logic [47:0] MAC = 48'h00_0A_35_01_FE_C0;
  localparam logic [31:0] LIP = 32'hC0_A8_00_02;
  localparam logic [31:0] TIP = 32'hC0_A8_00_03;
  localparam int PHY = 1000;
  localparam int IVL = 2000;
`ifdef ARP_TEST_FCS_EN
  localparam int N = 144;
`else
  localparam int N = 136;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txc = 1'b0;
  logic       en;
  logic [3:0] data;
  logic       rstn;

  arp_test #(
    .LOCAL_MAC(MAC), .LOCAL_IP(LIP), .TARGET_IP(TIP),
    .PHY_RST_CYCLES(PHY), .INTERVAL(IVL)
  ) dut (
    .clk(clk), .rst(rst), .ETH_TX_CLK(txc),
    .ETH_TX_EN(en), .ETH_TX_DATA(data), .ETH_RST_N(rstn)
  );

  always #10 clk = ~clk;
  initial begin
    #3;
    forever #22 txc = ~txc;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Nibble-advance strobe: the transmit clock falling edge as seen through two flops.
  logic [2:0] s;
  logic       strobe;
  longint     cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0; strobe <= 1'b0; cyc <= 0;
    end else begin
      strobe <= s[2] & ~s[1];
      s      <= {s[1:0], txc};
      cyc    <= cyc + 1;
    end
  end

  // Reference frame content.
  logic [7:0] eb[$];
  logic [3:0] expn[$];

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push(input logic [63:0] v, input int nb);
    logic [63:0] t;
    for (int i = nb - 1; i >= 0; i--) begin
      t = v >> (8 * i);
      eb.push_back(t[7:0]);
    end
  endtask

  // Captured frames and model state.
  logic [3:0] fr [8][160];
  int         fr_len [8];
  longint     fr_start [8];
  int         fr_gap [8];
  longint     fr_end [8];
  int         nframes = 0;
  int         cur = 0;
  int         gap_str = 0;
  int         cur_gap = 0;
  longint     cur_start = 0;
  longint     rise_cyc = -1;
  logic       prev_rstn = 1'b0;

  initial begin
    int     pos;
    int     gap;
    bit     armed;
    longint earliest;
    pos = -1; gap = 0; armed = 0; earliest = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_cyc_en", en, 1'b0);
        check("rst_cyc_data", data, 4'h0);
        check("rst_cyc_rstn", rstn, 1'b0);
        pos = -1; gap = 0; armed = 0;
        cur = 0; prev_rstn = 1'b0; rise_cyc = -1;
      end else begin
        if (cyc == PHY) begin
          armed = 1; earliest = cyc + IVL;
        end
        if (strobe) begin
          if (pos >= 0) begin
            pos++;
            if (pos == N) begin pos = -1; gap = 1; end
          end else if (gap > 0) begin
            if (gap == 24) begin gap = 0; earliest = cyc + IVL; end
            else gap++;
          end else if (armed && cyc > earliest) begin
            pos = 0;
          end
        end
        check("cyc_en", en, pos >= 0);
        check("cyc_data", data, (pos >= 0) ? expn[pos] : 4'h0);
        check("cyc_rstn", rstn, cyc >= PHY);

        if (rstn && !prev_rstn) rise_cyc = cyc;
        prev_rstn = rstn;
        if (strobe) begin
          if (en) begin
            if (cur == 0) begin cur_start = cyc; cur_gap = gap_str; end
            if (cur < 160) fr[nframes % 8][cur] = data;
            cur++;
          end else begin
            if (cur > 0) begin
              fr_len[nframes % 8]   = cur;
              fr_start[nframes % 8] = cur_start;
              fr_end[nframes % 8]   = cyc;
              fr_gap[nframes % 8]   = cur_gap;
              nframes++;
              cur = 0;
              gap_str = 0;
            end
            gap_str++;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (nframes < n && k < budget) begin @(negedge clk); k++; end
    check("frame_wait_timeout", nframes >= n, 1'b1);
  endtask

  task automatic wait_rise(input int budget);
    int k;
    k = 0;
    while (rise_cyc < 0 && k < budget) begin @(negedge clk); k++; end
    check("phy_rst_release_cyc", rise_cyc, PHY);
  endtask

  function automatic logic [7:0] cap_byte(input int f, input int b);
    return {fr[f][17 + 2 * b], fr[f][16 + 2 * b]};
  endfunction

  task automatic check_frame(input int f, input string tag);
    logic [159:0] v;
    int           diffs;
    check({tag, "_len"}, fr_len[f], N);
    v = '0;
    for (int i = 0; i < 16; i++) v[4 * i +: 4] = fr[f][i];
    check({tag, "_preamble"}, v, 64'hD555_5555_5555_5555);
    v = '0;
    for (int b = 0; b < 14; b++) v = (v << 8) | 160'(cap_byte(f, b));
    check({tag, "_eth_hdr"}, v, 112'hFFFFFFFFFFFF_000A3501FEC0_0806);
    v = '0;
    for (int b = 14; b < 22; b++) v = (v << 8) | 160'(cap_byte(f, b));
    check({tag, "_arp_fixed"}, v, 64'h0001_0800_0604_0001);
    v = '0;
    for (int b = 22; b < 42; b++) v = (v << 8) | 160'(cap_byte(f, b));
    check({tag, "_arp_addrs"}, v, 160'h000A3501FEC0_C0A80002_000000000000_C0A80003);
    v = '0;
    for (int b = 42; b < 60; b++) v = v | 160'(cap_byte(f, b));
    check({tag, "_padding"}, v, 160'h0);
`ifdef ARP_TEST_FCS_EN
    v = '0;
    for (int k = 0; k < 8; k++) v[4 * k +: 4] = fr[f][136 + k];
    check({tag, "_fcs"}, v, crc32(eb));
`endif
    if (f != 0) begin
      diffs = 0;
      for (int i = 0; i < N; i++) if (fr[f][i] !== fr[0][i]) diffs++;
      check({tag, "_same_as_first"}, diffs, 0);
    end
  endtask

  initial begin
    logic [7:0]  chk[$];
    logic [31:0] fcs;
    int          k;

    push(48'hFFFF_FFFF_FFFF, 6); push(MAC, 6); push(16'h0806, 2);
    push(16'h0001, 2); push(16'h0800, 2); push(8'h06, 1); push(8'h04, 1);
    push(16'h0001, 2); push(MAC, 6); push(LIP, 4); push(48'h0, 6); push(TIP, 4);
    for (int i = 0; i < 18; i++) push(64'h0, 1);
    for (int i = 0; i < 15; i++) expn.push_back(4'h5);
    expn.push_back(4'hD);
    foreach (eb[i]) begin expn.push_back(eb[i][3:0]); expn.push_back(eb[i][7:4]); end
`ifdef ARP_TEST_FCS_EN
    fcs = crc32(eb);
    for (int i = 0; i < 8; i++) expn.push_back(4'(fcs >> (4 * i)));
`endif

    // Pin the model itself.
    chk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_123456789", crc32(chk), 32'hCBF4_3926);
    check("model_len", expn.size(), N);
    check("model_byte12_13", {eb[12], eb[13]}, 16'h0806);
    check("model_target_ip", {eb[38], eb[39], eb[40], eb[41]}, 32'hC0A8_0003);

    repeat (5) @(posedge clk);
    #5;
    check("reset_en", en, 1'b0);
    check("reset_data", data, 4'h0);
    check("reset_rstn", rstn, 1'b0);
    rst = 1'b0;

    wait_rise(3000);
    wait_frames(1, 8000);
    check("frame1_start_window", fr_start[0] >= PHY + IVL + 1 && fr_start[0] <= PHY + IVL + 3, 1'b1);
    check_frame(0, "frame1");

    wait_frames(2, 8000);
    check_frame(1, "frame2");
    check("frame2_gap_nibbles", fr_gap[1] >= 24, 1'b1);
    check("frame2_gap_cycles", fr_start[1] - fr_end[0] >= IVL + 48, 1'b1);

    // Abort the third frame at nibble 50.
    k = 0;
    while (!(nframes == 2 && cur >= 50) && k < 8000) begin @(negedge clk); k++; end
    check("midframe_reach_timeout", nframes == 2 && cur >= 50, 1'b1);
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check("midframe_rst_en", en, 1'b0);
    check("midframe_rst_rstn", rstn, 1'b0);
    check("midframe_rst_data", data, 4'h0);
    repeat (3) @(posedge clk);
    #5;
    rst = 1'b0;

    wait_rise(3000);
    wait_frames(3, 8000);
    check("frame3_start_window", fr_start[2] >= PHY + IVL + 1 && fr_start[2] <= PHY + IVL + 3, 1'b1);
    check_frame(2, "frame3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
